// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch time base and the stages that consume its time bus.
package stopwatch_pkg;

  localparam int TIME_W_DEFAULT = 39;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Time bus as seen by downstream stages such as the LED blink logic.
  typedef logic [TIME_W_DEFAULT-1:0] time_bus_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one time-unit tick; the count holds while disabled so a paused
// stopwatch keeps its fractional unit.
module tick_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_d;

  assign tick = enable && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = presc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Elapsed-time generator: run/pause/clear FSM counting prescaled ticks onto time_out.
// Optional lap hold on time_out is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int                CLK_DIV  = 100000,
  parameter int                TIME_W   = TIME_W_DEFAULT,
  parameter logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop_pulse,
  input  logic              clear_pulse,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic              lap_pulse,
  output logic              lap_active,
`endif
  output logic [TIME_W-1:0] time_out,
  output logic              running,
  output logic              tick_out,
  output logic              wrap_pulse
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("stopwatch_timebase: CLK_DIV must be at least 2");
  end

  state_t            state_q, state_d;
  logic [TIME_W-1:0] count_q, count_d;
  logic              running_q;
  logic              tickOut_q;
  logic              wrapPulse_q;

  logic              prescEnable;
  logic              prescClear;
  logic              unitTick;
  logic              atMax;

  // Clear beats everything, including a tick landing on the same edge.
  assign prescEnable = (state_q == RUN) && !clear_pulse;
  assign prescClear  = clear_pulse || (state_q == IDLE);
  assign atMax       = (count_q == TIME_MAX);

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (prescEnable),
    .clear  (prescClear),
    .tick   (unitTick)
  );

  always_comb begin
    state_d = state_q;
    if (clear_pulse) begin
      state_d = IDLE;
    end else if (start_stop_pulse) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (prescClear) begin
      count_d = '0;
    end else if (unitTick) begin
      count_d = atMax ? '0 : count_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      running_q   <= 1'b0;
      tickOut_q   <= 1'b0;
      wrapPulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      running_q   <= (state_d == RUN);
      tickOut_q   <= unitTick;
      wrapPulse_q <= unitTick && atMax;
    end
  end

  assign running    = running_q;
  assign tick_out   = tickOut_q;
  assign wrap_pulse = wrapPulse_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [TIME_W-1:0] lapHold_q, lapHold_d;
  logic              lapActive_q, lapActive_d;
  logic [TIME_W-1:0] timeOut_q, timeOut_d;

  // The hold captures the count as displayed before this edge, so time_out never jumps on a lap.
  always_comb begin
    lapHold_d   = lapHold_q;
    lapActive_d = lapActive_q;
    if (clear_pulse) begin
      lapActive_d = 1'b0;
    end else if (lap_pulse) begin
      if (lapActive_q && (state_q != IDLE)) begin
        lapActive_d = 1'b0;
      end else if (!lapActive_q && (state_q == RUN)) begin
        lapHold_d   = count_q;
        lapActive_d = 1'b1;
      end
    end
    timeOut_d = lapActive_d ? lapHold_d : count_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lapHold_q   <= '0;
      lapActive_q <= 1'b0;
      timeOut_q   <= '0;
    end else begin
      lapHold_q   <= lapHold_d;
      lapActive_q <= lapActive_d;
      timeOut_q   <= timeOut_d;
    end
  end

  assign time_out   = timeOut_q;
  assign lap_active = lapActive_q;
`else
  assign time_out = count_q;
`endif

endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
- Elapsed-time generator that sits directly upstream of the LED blink stage and produces the 39-bit `time_out` bus that stage samples.
- Divides `clk` down to a time-unit tick and counts ticks while running.
- Responds to start/stop and clear pulses from the button-conditioning stage.
- Downstream consumers use individual bits of `time_out` (e.g. bit 8 toggles every 256 ticks).

Parameters:
- CLK_DIV, 100000, clk cycles per time unit; legal range ≥ 2 (elaboration-time check).
- TIME_W, 39, width of the elapsed-time count.
- TIME_MAX, 2**39-1, last count value before wrap; must fit in TIME_W bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start_stop_pulse  input  1  one-cycle pulse; toggles run/pause.
- clear_pulse  input  1  one-cycle pulse; returns to zero/idle.
- time_out  output  TIME_W  elapsed time units, registered.
- running  output  1  high while in RUN.
- tick_out  output  1  one-cycle pulse on every count increment.
- wrap_pulse  output  1  one-cycle pulse when count wraps TIME_MAX→0.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values: time_out=0, running=0, tick_out=0, wrap_pulse=0, prescaler=0, state=IDLE. Reset overrides all inputs.
- FSM states and transitions:
  - IDLE: count=0, prescaler=0. start_stop_pulse→RUN.
  - RUN: start_stop_pulse→PAUSE.
  - PAUSE: start_stop_pulse→RUN.
  - Any state: clear_pulse→IDLE, count=0, prescaler=0.
- running is registered and equals (state==RUN) from the same edge the state changes.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN.
  - Holds its value in PAUSE, so the fractional unit is preserved across pause/resume.
  - Forced to 0 in IDLE.
- Tick: on the edge where state==RUN and prescaler==CLK_DIV-1:
  - prescaler←0, count←count+1, tick_out←1 (all on the same edge).
  - time_out therefore changes on the same edge tick_out rises.
- Latency: first increment occurs exactly CLK_DIV cycles after the edge that enters RUN from IDLE.
- Wrap: a tick with count==TIME_MAX sets count←0 and asserts wrap_pulse together with tick_out. Counting continues.
- Simultaneous events:
  - clear_pulse with start_stop_pulse: clear wins and start_stop is ignored (ends in IDLE).
  - clear_pulse on a tick cycle: clear wins; no tick_out or wrap_pulse.
  - start_stop_pulse in RUN on a tick cycle: the tick still takes effect (count increments, tick_out=1) and the state goes to PAUSE.
- Reset mid-run: everything returns to reset values on that edge; no partial tick.
- Pulses held high for multiple cycles toggle every cycle. Upstream guarantees single-cycle pulses; the bench checks toggle-per-cycle behaviour.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds input `lap_pulse` (1 bit) and output `lap_active` (1 bit, reset 0).
  - In RUN, lap_pulse with lap_active=0 latches the current count into a hold register and sets lap_active. time_out then shows the held value while the internal count keeps running.
  - lap_pulse with lap_active=1 (in RUN or PAUSE) releases the hold; time_out shows the live count on the next edge.
  - lap_pulse in IDLE, or in PAUSE with lap_active=0, is ignored.
  - clear_pulse or reset releases the hold.
  - tick_out and wrap_pulse always follow the internal count.
- Not defined: ports absent; time_out always equals the internal count.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE}.
  - TIME_W default constant.
  - Shared time-bus typedef (logic [TIME_W-1:0]) for downstream stages.
- One natural sub-module, tick_prescaler:
  - Parameter CLK_DIV.
  - Inputs clk, reset, enable, clear.
  - Output tick (combinational terminal-count flag, registered in the parent).

Test Plan (CLK_DIV=4 unless noted):
- Reset then start_stop_pulse at cycle 0 → running=1 next edge; tick_out and time_out=1 at cycle 4, time_out=2 at cycle 8; 256 ticks → time_out[8] rises.
- RUN 6 cycles (time_out=1, prescaler=2) → pause 10 cycles with time_out held at 1 → resume → next increment exactly 2 cycles after resume.
- clear_pulse and start_stop_pulse asserted together while RUN with time_out=5 → IDLE, time_out=0, running=0, no tick_out.
- TIME_MAX=9: run to 9, next tick → time_out=0 with tick_out=1 and wrap_pulse=1 on the same cycle; counting continues to 1.
- start_stop_pulse on a terminal-count cycle at time_out=3 → time_out=4, tick_out=1, state PAUSE; no further increments for 20 cycles.
- STOPWATCH_LAP_HOLD_EN:
  - lap_pulse at time_out=7 → time_out stays 7 for 12 cycles while the internal count reaches 10.
  - Second lap_pulse → time_out=10 (live count) next edge, lap_active=0.
  - reset mid-hold → all outputs 0.
